// File: rtl/mips_pkg.sv
// mips_pkg: mnemonic enum, MIPS opcode/funct encodings and loader FSM states.
// Shared by the instruction encoder, the loader top level and its bench.
package mips_pkg;

   typedef enum logic [4:0] {
      NEM_ZERO  = 5'd0,
      NEM_ADD   = 5'd1,
      NEM_AND   = 5'd2,
      NEM_OR    = 5'd3,
      NEM_SLT   = 5'd4,
      NEM_SUB   = 5'd5,
      NEM_XOR   = 5'd6,
      NEM_ADDI  = 5'd7,
      NEM_ADDIU = 5'd8,
      NEM_BEQ   = 5'd9,
      NEM_LW    = 5'd10,
      NEM_SW    = 5'd11,
      NEM_ABS   = 5'd12,
      NEM_JUMP  = 5'd13,
      NEM_BNE   = 5'd14,
      NEM_NOR   = 5'd15
   } t_instr_pnmen;

   localparam logic [5:0] ZERO  = 6'h00;
   localparam logic [5:0] JUMP  = 6'h02;
   localparam logic [5:0] BEQ   = 6'h04;
   localparam logic [5:0] ADDI  = 6'h08;
   localparam logic [5:0] ADDIU = 6'h09;
   localparam logic [5:0] ABS   = 6'h1c;
   localparam logic [5:0] LW    = 6'h23;
   localparam logic [5:0] SW    = 6'h2b;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_XOR = 6'h26;
   localparam logic [5:0] F_SLT = 6'h2a;

   typedef enum logic [1:0] {
      LD_IDLE,
      LD_LOAD,
      LD_DONE
   } t_loader_state;

   function automatic logic [31:0] r_type(
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic [4:0] rd,
      input logic [5:0] funct
   );
      return {ZERO, rs, rt, rd, 5'b0, funct};
   endfunction

endpackage

// File: rtl/mips_instr_loader_encoder.sv
// instr_encoder: combinational mnemonic-to-MIPS-word encoder.
// Mnemonics without an encoding raise illegal and yield a zero word.
module instr_encoder
   import mips_pkg::*;
(
   input  t_instr_pnmen pnem,
   input  logic [4:0]   rs,
   input  logic [4:0]   rt,
   input  logic [4:0]   rd,
   input  logic [15:0]  imm,
   input  logic [25:0]  target,
   output logic [31:0]  word,
   output logic         illegal
);

   always_comb begin
      word    = 32'h0;
      illegal = 1'b0;
      case (pnem)
         NEM_ADD:   word = r_type(rs, rt, rd, F_ADD);
         NEM_AND:   word = r_type(rs, rt, rd, F_AND);
         NEM_OR:    word = r_type(rs, rt, rd, F_OR);
         NEM_SLT:   word = r_type(rs, rt, rd, F_SLT);
         NEM_SUB:   word = r_type(rs, rt, rd, F_SUB);
         NEM_XOR:   word = r_type(rs, rt, rd, F_XOR);
         NEM_ZERO:  word = 32'h0;
         NEM_ADDI:  word = {ADDI, rs, rt, imm};
         NEM_ADDIU: word = {ADDIU, rs, rt, imm};
         NEM_BEQ:   word = {BEQ, rs, rt, imm};
         NEM_LW:    word = {LW, rs, rt, imm};
         NEM_SW:    word = {SW, rs, rt, imm};
         NEM_ABS:   word = {ABS, rs, rt, 16'h0};
         NEM_JUMP:  word = {JUMP, target};
         default:   illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_instr_loader.sv
// mips_instr_loader: encodes handshaked commands and writes them to imem.
// Optional running XOR checksum of written words under LOADER_CHECKSUM_EN.
module mips_instr_loader
   import mips_pkg::*;
#(
   parameter int IMEM_DEPTH = 64,
   parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  t_instr_pnmen      cmd_pnem,
   input  logic [4:0]        cmd_rs,
   input  logic [4:0]        cmd_rt,
   input  logic [4:0]        cmd_rd,
   input  logic [15:0]       cmd_imm,
   input  logic [25:0]       cmd_target,
   input  logic              cmd_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              load_done,
   output logic [ADDR_W:0]   words_written,
   output logic              err_illegal,
   output logic              err_overflow,
   output logic [31:0]       checksum
);

   localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(IMEM_DEPTH - 1);
   localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

   t_loader_state     state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              done_q, done_d;
   logic              ill_q, ill_d;
   logic              ovf_q, ovf_d;

   logic [31:0]       enc_word;
   logic              enc_illegal;
   logic              accept;
   logic              clear;

   instr_encoder u_enc (
      .pnem    (cmd_pnem),
      .rs      (cmd_rs),
      .rt      (cmd_rt),
      .rd      (cmd_rd),
      .imm     (cmd_imm),
      .target  (cmd_target),
      .word    (enc_word),
      .illegal (enc_illegal)
   );

   assign cmd_ready = (state_q == LD_LOAD) && !load_start;
   assign accept    = cmd_valid && cmd_ready;
   assign clear     = load_start && (state_q != LD_DONE);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      done_d  = 1'b0;
      ill_d   = ill_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         LD_IDLE: begin
            if (load_start) state_d = LD_LOAD;
         end
         LD_LOAD: begin
            if (accept) begin
               if (enc_illegal) begin
                  ill_d = 1'b1;
               end else begin
                  we_d    = 1'b1;
                  addr_d  = count_q[ADDR_W-1:0];
                  wdata_d = enc_word;
                  count_d = count_q + ONE;
                  // memory full with more program to come: stop, no wrap
                  if (!cmd_last && count_q == LAST_ADDR) begin
                     ovf_d   = 1'b1;
                     state_d = LD_DONE;
                  end
               end
               if (cmd_last) state_d = LD_DONE;
            end
         end
         LD_DONE: begin
            done_d  = 1'b1;
            state_d = LD_IDLE;
         end
         default: state_d = LD_IDLE;
      endcase
      if (clear) begin
         count_d = '0;
         ill_d   = 1'b0;
         ovf_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= LD_IDLE;
         count_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         done_q  <= 1'b0;
         ill_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         ill_q   <= ill_d;
         ovf_q   <= ovf_d;
      end
   end

   assign imem_we       = we_q;
   assign imem_addr     = addr_q;
   assign imem_wdata    = wdata_q;
   assign load_done     = done_q;
   assign words_written = count_q;
   assign err_illegal   = ill_q;
   assign err_overflow  = ovf_q;

`ifdef LOADER_CHECKSUM_EN
   logic [31:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if (clear) checksum_d = 32'h0;
      else if (we_d) checksum_d = checksum_q ^ enc_word;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) checksum_q <= 32'h0;
      else      checksum_q <= checksum_d;
   end

   assign checksum = checksum_q;
`else
   assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_mips_instr_loader.sv
// tb_mips_instr_loader: directed vectors with a write scoreboard.
// Runs a depth-64 loader for the main cases and a depth-4 one for overflow.
module tb_mips_instr_loader;
   import mips_pkg::*;

`ifdef LOADER_CHECKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ls_b = 1'b0;
   logic ls_s = 1'b0;
   logic cmd_valid = 1'b0;
   logic cmd_last = 1'b0;
   t_instr_pnmen cmd_pnem = NEM_ZERO;
   logic [4:0]  cmd_rs = '0;
   logic [4:0]  cmd_rt = '0;
   logic [4:0]  cmd_rd = '0;
   logic [15:0] cmd_imm = '0;
   logic [25:0] cmd_target = '0;

   logic        b_ready, b_we, b_done, b_ill, b_ovf;
   logic [5:0]  b_addr;
   logic [31:0] b_wdata, b_ck;
   logic [6:0]  b_ww;

   logic        s_ready, s_we, s_done, s_ill, s_ovf;
   logic [1:0]  s_addr;
   logic [31:0] s_wdata, s_ck;
   logic [2:0]  s_ww;

   mips_instr_loader #(.IMEM_DEPTH(64)) u_big (
      .clk(clk), .rst(rst), .load_start(ls_b),
      .cmd_valid(cmd_valid), .cmd_ready(b_ready),
      .cmd_pnem(cmd_pnem), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
      .cmd_rd(cmd_rd), .cmd_imm(cmd_imm), .cmd_target(cmd_target),
      .cmd_last(cmd_last), .imem_we(b_we), .imem_addr(b_addr),
      .imem_wdata(b_wdata), .load_done(b_done),
      .words_written(b_ww), .err_illegal(b_ill),
      .err_overflow(b_ovf), .checksum(b_ck)
   );

   mips_instr_loader #(.IMEM_DEPTH(4)) u_small (
      .clk(clk), .rst(rst), .load_start(ls_s),
      .cmd_valid(cmd_valid), .cmd_ready(s_ready),
      .cmd_pnem(cmd_pnem), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
      .cmd_rd(cmd_rd), .cmd_imm(cmd_imm), .cmd_target(cmd_target),
      .cmd_last(cmd_last), .imem_we(s_we), .imem_addr(s_addr),
      .imem_wdata(s_wdata), .load_done(s_done),
      .words_written(s_ww), .err_illegal(s_ill),
      .err_overflow(s_ovf), .checksum(s_ck)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        q_b[$];
   exp_t        q_s[$];
   exp_t        eb, es;
   int          n_chk = 0;
   int          n_fail = 0;
   int          m_cnt[2];
   logic [31:0] m_ck[2];
   int          last_we_b = -10;
   int          last_we_s = -10;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm, input string msg);
      n_chk++;
      n_fail++;
      $display("FAIL %s: %s", nm, msg);
   endtask

   function automatic logic [31:0] exp_ck(input int sel);
      return CK_EN ? m_ck[sel] : 32'h0;
   endfunction

   always @(negedge clk) begin
      if (b_done) chk("b_done_lat", cyc, last_we_b + 1);
      if (b_we) begin
         if (q_b.size() == 0) begin
            fail("b_unexp_we", $sformatf("write addr %0d data %h", b_addr, b_wdata));
         end else begin
            eb = q_b.pop_front();
            chk("b_addr", b_addr, eb.addr);
            chk("b_data", b_wdata, eb.data);
            chk("b_lat", cyc, eb.cyc);
         end
         last_we_b = cyc;
      end
   end

   always @(negedge clk) begin
      if (s_done) chk("s_done_lat", cyc, last_we_s + 1);
      if (s_we) begin
         if (q_s.size() == 0) begin
            fail("s_unexp_we", $sformatf("write addr %0d data %h", s_addr, s_wdata));
         end else begin
            es = q_s.pop_front();
            chk("s_addr", s_addr, es.addr);
            chk("s_data", s_wdata, es.data);
            chk("s_lat", cyc, es.cyc);
         end
         last_we_s = cyc;
      end
   end

   task automatic send(input int sel, input t_instr_pnmen p,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic last,
                       input logic legal, input logic [31:0] w);
      int   waits;
      logic rdy;
      exp_t e;
      waits = 0;
      cmd_pnem = p;
      cmd_rs = rs;
      cmd_rt = rt;
      cmd_rd = rd;
      cmd_imm = imm;
      cmd_target = tgt;
      cmd_last = last;
      cmd_valid = 1'b1;
      forever begin
         @(negedge clk);
         rdy = (sel != 0) ? s_ready : b_ready;
         if (rdy) break;
         waits++;
         if (waits > 20) begin
            fail("send_timeout", "cmd_ready never asserted");
            cmd_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_last = 1'b0;
      if (legal) begin
         e.addr = m_cnt[sel];
         e.data = w;
         e.cyc = cyc;
         if (sel != 0) q_s.push_back(e);
         else q_b.push_back(e);
         m_cnt[sel]++;
         m_ck[sel] ^= w;
      end
   endtask

   task automatic start_load(input int sel);
      if (sel != 0) ls_s = 1'b1;
      else ls_b = 1'b1;
      @(posedge clk);
      #1;
      ls_s = 1'b0;
      ls_b = 1'b0;
      m_cnt[sel] = 0;
      m_ck[sel] = 32'h0;
   endtask

   task automatic wait_done(input int sel, input int ww,
                            input logic ill, input logic ovf);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if ((sel != 0) ? s_done : b_done) begin
            if (sel != 0) begin
               chk("s_ww", s_ww, ww);
               chk("s_ill", s_ill, ill);
               chk("s_ovf", s_ovf, ovf);
               chk("s_ck", s_ck, exp_ck(1));
               chk("s_ready_after", s_ready, 0);
               chk("s_q_empty", q_s.size(), 0);
            end else begin
               chk("b_ww", b_ww, ww);
               chk("b_ill", b_ill, ill);
               chk("b_ovf", b_ovf, ovf);
               chk("b_ck", b_ck, exp_ck(0));
               chk("b_ready_after", b_ready, 0);
               chk("b_q_empty", q_b.size(), 0);
            end
            @(negedge clk);
            chk("done_pulse", (sel != 0) ? s_done : b_done, 0);
            @(posedge clk);
            #1;
            return;
         end
      end
      fail("done_timeout", "load_done never pulsed");
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_we"}, b_we, 0);
      chk({tag, "_addr"}, b_addr, 0);
      chk({tag, "_wdata"}, b_wdata, 0);
      chk({tag, "_done"}, b_done, 0);
      chk({tag, "_ww"}, b_ww, 0);
      chk({tag, "_ill"}, b_ill, 0);
      chk({tag, "_ovf"}, b_ovf, 0);
      chk({tag, "_ck"}, b_ck, 0);
      chk({tag, "_ready"}, b_ready, 0);
   endtask

   initial begin
      int c0;
      m_cnt = '{0, 0};
      m_ck = '{32'h0, 32'h0};
      repeat (3) @(negedge clk);
      chk_zero("rst");
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;

      // single ADD r3,r1,r2 with last
      start_load(0);
      send(0, NEM_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 1'b1, 32'h00221820);
      wait_done(0, 1, 1'b0, 1'b0);

      // back-to-back LW, SW, BEQ, J
      start_load(0);
      c0 = cyc;
      send(0, NEM_LW, 5'd4, 5'd5, 5'd0, 16'd8, 26'h0, 1'b0, 1'b1, 32'h8C850008);
      send(0, NEM_SW, 5'd4, 5'd5, 5'd0, 16'd12, 26'h0, 1'b0, 1'b1, 32'hAC85000C);
      send(0, NEM_BEQ, 5'd1, 5'd2, 5'd0, 16'd3, 26'h0, 1'b0, 1'b1, 32'h10220003);
      send(0, NEM_JUMP, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40, 1'b1, 1'b1, 32'h08000040);
      chk("b2b_cycles", cyc - c0, 4);
      wait_done(0, 4, 1'b0, 1'b0);

      // illegal mnemonic between two ADDIs
      start_load(0);
      send(0, NEM_ADDI, 5'd0, 5'd1, 5'd0, 16'd5, 26'h0, 1'b0, 1'b1, 32'h20010005);
      send(0, NEM_BNE, 5'd1, 5'd2, 5'd0, 16'd7, 26'h0, 1'b0, 1'b0, 32'h0);
      send(0, NEM_ADDI, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b1, 1'b1, 32'h2022FFFF);
      wait_done(0, 2, 1'b1, 1'b0);

      // depth-4 overflow, load_start in DONE ignored
      start_load(1);
      for (int i = 0; i < 4; i++)
         send(1, NEM_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00221820);
      cmd_valid = 1'b1;
      ls_s = 1'b1;
      @(posedge clk);
      #1 ls_s = 1'b0;
      wait_done(1, 4, 1'b0, 1'b1);
      @(negedge clk);
      chk("s_ready_idle", s_ready, 0);
      chk("s_ovf_sticky", s_ovf, 1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;

      // restart mid-load after 3 writes
      start_load(0);
      send(0, NEM_SUB, 5'd5, 5'd6, 5'd4, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00A62022);
      send(0, NEM_BNE, 5'd1, 5'd1, 5'd0, 16'h1, 26'h0, 1'b0, 1'b0, 32'h0);
      send(0, NEM_ABS, 5'd3, 5'd4, 5'd0, 16'h0, 26'h0, 1'b0, 1'b1, 32'h70640000);
      send(0, NEM_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00221820);
      cmd_valid = 1'b1;
      ls_b = 1'b1;
      @(negedge clk);
      chk("restart_ready", b_ready, 0);
      @(posedge clk);
      #1;
      ls_b = 1'b0;
      cmd_valid = 1'b0;
      m_cnt[0] = 0;
      m_ck[0] = 32'h0;
      @(negedge clk);
      chk("restart_ww", b_ww, 0);
      chk("restart_ill", b_ill, 0);
      chk("restart_ck", b_ck, 0);
      @(posedge clk);
      #1;
      send(0, NEM_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00221820);
      send(0, NEM_ZERO, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1, 1'b1, 32'h0);
      wait_done(0, 2, 1'b0, 1'b0);

      // asynchronous reset with a write pending
      start_load(0);
      send(0, NEM_ADDIU, 5'd2, 5'd3, 5'd0, 16'h10, 26'h0, 1'b0, 1'b1, 32'h24430010);
      #1 rst = 1'b0;
      #1 chk_zero("mid_rst");
      q_b.delete();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;

      chk("final_q_b", q_b.size(), 0);
      chk("final_q_s", q_s.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/mips_instr_loader.md
# mips_instr_loader

Instruction encoder and loader: accepts mnemonic-level commands (pnemonic plus register, immediate and target fields) over a valid/ready handshake, encodes each into the 32-bit MIPS word that the control decoder consumes, and writes it sequentially into instruction memory. It sits between the testbench or boot-loader front end and the instruction-memory write port, ahead of fetch.

## Interface
- IMEM_DEPTH, 64, instruction-memory depth in words; power of two, ≥2
- ADDR_W, $clog2(IMEM_DEPTH), word-address width
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- load_start  in  1  one-cycle pulse; begins or restarts a load at word 0
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready at a rising edge
- cmd_pnem  in  t_instr_pnmen  mnemonic
- cmd_rs, cmd_rt, cmd_rd  in  5 each  register fields
- cmd_imm  in  16  immediate / branch offset
- cmd_target  in  26  jump target
- cmd_last  in  1  final command of the program
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- load_done  out  1  one-cycle pulse at end of load
- words_written  out  ADDR_W+1  words written in current or last load
- err_illegal  out  1  sticky; unsupported mnemonic seen
- err_overflow  out  1  sticky; memory filled before cmd_last
- checksum  out  32  running XOR of written words

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE: on load_start go to LOAD; clear count, err_illegal, err_overflow and checksum.
- LOAD: cmd_ready = 1 unless load_start is high. load_start in LOAD restarts: count and flags are cleared, the state stays LOAD, and no command is accepted in that cycle.
- Encoding of an accepted command:
  - NEM_ADD/AND/OR/SLT/SUB/XOR: {ZERO, rs, rt, rd, 5'b0, funct}.
  - NEM_ZERO: 32'h0.
  - NEM_ADDI/ADDIU/BEQ/LW/SW: {opcode, rs, rt, imm}.
  - NEM_ABS: {ABS, rs, rt, 16'h0}.
  - NEM_JUMP: {JUMP, target}.
- Writes and count:
  - A legal command produces one write at imem_addr = count, then count increments.
  - An illegal or unsupported mnemonic is accepted and consumed, but produces no write and no count increment; err_illegal is set.
- Leaving LOAD:
  - An accepted command with cmd_last moves the FSM to DONE, whether the command was legal or illegal.
  - A legal write at count = IMEM_DEPTH−1 without cmd_last moves the FSM to DONE and sets err_overflow. No address wrap occurs.
- DONE: load_done = 1 for one cycle, then the FSM returns to IDLE. load_start in DONE is ignored.
- Reset values: all outputs are 0, the state is IDLE, and checksum is 0.

## Timing
- Latency is 1 cycle: a command accepted at edge N drives imem_we/addr/wdata during cycle N+1, captured at edge N+1.
- Throughput is one command per cycle, with no bubbles.
- cmd_ready is combinational from state and load_start only. It never depends on cmd_valid.
- load_done asserts in the cycle after the final write, i.e. the cycle after imem_we for the last word.
- words_written updates in the same cycle imem_we is high.
- If reset asserts mid-load, everything clears asynchronously. A write that was pending is dropped.

## Configuration
- LOADER_CHECKSUM_EN defined: checksum is updated as checksum ^ imem_wdata on every write, and cleared on load_start.
- LOADER_CHECKSUM_EN undefined: checksum is tied to 32'h0 and no register is inferred. All other behaviour is identical.

## Structure
- mips_pkg: t_instr_pnmen, opcode and funct constants, and a new t_loader_state enum (LD_IDLE, LD_LOAD, LD_DONE).
- Sub-module instr_encoder: purely combinational. It maps pnemonic and fields to a 32-bit word plus an illegal flag.
- Top level: FSM, address counter, output register stage, and the optional checksum.

## Test plan
- ADD r3,r1,r2 then cmd_last → word 0 = 32'h00221820; load_done one cycle later; words_written = 1.
- LW r5,8(r4); SW r5,12(r4); BEQ r1,r2,+3; J 0x40, the last with cmd_last → words 0–3 encoded per package opcodes; imem_addr 0,1,2,3 on consecutive cycles with back-to-back valid.
- Illegal pnemonic between two ADDIs → only 2 writes, at addresses 0 and 1; err_illegal = 1; words_written = 2.
- IMEM_DEPTH = 4, six commands with no cmd_last → 4 writes, err_overflow = 1, load_done pulses, cmd_ready = 0 afterwards.
- load_start pulsed mid-load after 3 writes → next accepted command writes address 0; flags and checksum cleared.
- With LOADER_CHECKSUM_EN: writes of 32'h00221820 and 32'h0 → checksum = 32'h00221820. Without the macro → 0. Reset asserted mid-load → all outputs 0 immediately.
